// File: rtl/snake_motion_sequencer.sv
// Snake state keeper: shifts the body, advances the head, grows on fruit, detects collisions
// and streams body segments to the renderer. Define SNAKE_WALL_WRAP_EN for wrap-around edges.
module snake_motion_sequencer #(
    parameter int SNAKE_LENGTH_BIT = 4,
    parameter int SNAKE_LENGTH_MAX = 16,
    parameter int GRID_W           = 124,
    parameter int GRID_H           = 81,
    parameter int INIT_LENGTH      = 3,
    parameter int INIT_X           = 60,
    parameter int INIT_Y           = 40
) (
    input  logic                        clock_25,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        move_tick,
    input  logic                        up,
    input  logic                        down,
    input  logic                        left,
    input  logic                        right,
    input  logic [6:0]                  fruit_x,
    input  logic [6:0]                  fruit_y,
    output logic [6:0]                  snake_head_x,
    output logic [6:0]                  snake_head_y,
    output logic [6:0]                  snake_body_x,
    output logic [6:0]                  snake_body_y,
    output logic [SNAKE_LENGTH_BIT-1:0] body_count,
    output logic [SNAKE_LENGTH_BIT-1:0] snake_length,
    output logic                        fruit_eaten,
    output logic                        game_over,
    output logic                        busy
);

    // Length needs one extra bit so that a full array (SNAKE_LENGTH_MAX) is representable.
    localparam int LW = SNAKE_LENGTH_BIT + 1;

    typedef enum logic [2:0] {
        ST_STREAM,
        ST_SHIFT,
        ST_HEAD,
        ST_CHECK,
        ST_OVER
    } state_t;

    typedef enum logic [1:0] {
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    state_t                      state;
    state_t                      state_next;
    dir_t                        dir;
    dir_t                        dir_req;
    dir_t                        dir_cand;
    logic                        cand_valid;
    logic [LW-1:0]               len;
    logic [SNAKE_LENGTH_BIT-1:0] idx;
    logic [SNAKE_LENGTH_BIT-1:0] idx_prev;
    logic [SNAKE_LENGTH_BIT-1:0] last_idx;
    logic [SNAKE_LENGTH_BIT-1:0] shift_first;
    logic [SNAKE_LENGTH_BIT-1:0] stream_next;
    logic                        grow_pending;
    logic                        grow_now;
    logic                        check_hit;
    logic [6:0]                  head_x;
    logic [6:0]                  head_y;
    logic [6:0]                  step_x;
    logic [6:0]                  step_y;
    logic                        step_off_grid;
    logic [6:0]                  body_x [SNAKE_LENGTH_MAX];
    logic [6:0]                  body_y [SNAKE_LENGTH_MAX];

    function automatic logic [6:0] init_body_x(input int k);
        return (k < INIT_LENGTH) ? 7'(INIT_X - 1 - k) : 7'd0;
    endfunction

    function automatic logic [6:0] init_body_y(input int k);
        return (k < INIT_LENGTH) ? 7'(INIT_Y) : 7'd0;
    endfunction

    function automatic dir_t opposite(input dir_t d);
        case (d)
            DIR_UP:   return DIR_DOWN;
            DIR_DOWN: return DIR_UP;
            DIR_LEFT: return DIR_RIGHT;
            default:  return DIR_LEFT;
        endcase
    endfunction

    assign last_idx    = SNAKE_LENGTH_BIT'(len - LW'(1));
    assign idx_prev    = idx - SNAKE_LENGTH_BIT'(1);
    assign grow_now    = grow_pending && (len < LW'(SNAKE_LENGTH_MAX));
    // A growth step starts one index higher: its first shift copies the tail into body[len].
    assign shift_first = grow_now ? SNAKE_LENGTH_BIT'(len) : last_idx;
    assign stream_next = (body_count >= last_idx) ? '0 : body_count + SNAKE_LENGTH_BIT'(1);
    assign check_hit   = (body_x[idx] == head_x) && (body_y[idx] == head_y);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cand_valid = 1'b1;
        dir_cand   = dir;
        if (up)         dir_cand = DIR_UP;
        else if (down)  dir_cand = DIR_DOWN;
        else if (right) dir_cand = DIR_RIGHT;
        else if (left)  dir_cand = DIR_LEFT;
        else            cand_valid = 1'b0;
        dir_req = (cand_valid && dir_cand != opposite(dir)) ? dir_cand : dir;
    end

    always_comb begin
        step_x        = head_x;
        step_y        = head_y;
        step_off_grid = 1'b0;
        case (dir)
            DIR_UP: begin
                if (head_y == 7'd0) begin
`ifdef SNAKE_WALL_WRAP_EN
                    step_y = 7'(GRID_H - 1);
`else
                    step_off_grid = 1'b1;
`endif
                end else begin
                    step_y = head_y - 7'd1;
                end
            end
            DIR_DOWN: begin
                if (head_y == 7'(GRID_H - 1)) begin
`ifdef SNAKE_WALL_WRAP_EN
                    step_y = 7'd0;
`else
                    step_off_grid = 1'b1;
`endif
                end else begin
                    step_y = head_y + 7'd1;
                end
            end
            DIR_LEFT: begin
                if (head_x == 7'd0) begin
`ifdef SNAKE_WALL_WRAP_EN
                    step_x = 7'(GRID_W - 1);
`else
                    step_off_grid = 1'b1;
`endif
                end else begin
                    step_x = head_x - 7'd1;
                end
            end
            default: begin
                if (head_x == 7'(GRID_W - 1)) begin
`ifdef SNAKE_WALL_WRAP_EN
                    step_x = 7'd0;
`else
                    step_off_grid = 1'b1;
`endif
                end else begin
                    step_x = head_x + 7'd1;
                end
            end
        endcase
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock_25 or posedge reset) begin
        if (reset) state <= ST_STREAM;
        else       state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_STREAM: if (move_tick) state_next = (shift_first != '0) ? ST_SHIFT : ST_HEAD;
            ST_SHIFT:  if (idx == SNAKE_LENGTH_BIT'(1)) state_next = ST_HEAD;
            ST_HEAD:   state_next = step_off_grid ? ST_OVER : ST_CHECK;
            ST_CHECK: begin
                if (check_hit)            state_next = ST_OVER;
                else if (idx == last_idx) state_next = ST_STREAM;
            end
            ST_OVER:   if (start) state_next = ST_STREAM;
            default:   state_next = ST_STREAM;
        endcase
    end

    // Output logic.
    always_comb begin
        busy      = 1'b0;
        game_over = 1'b0;
        case (state)
            ST_SHIFT, ST_HEAD, ST_CHECK: busy = 1'b1;
            ST_OVER:                     game_over = 1'b1;
            default:                     ;
        endcase
    end

    // Datapath: snake state, step bookkeeping and the segment stream.
    // NOTE: the body array is reset explicitly because the game relies on its initial contents.
    always_ff @(posedge clock_25 or posedge reset) begin
        if (reset) begin
            head_x       <= 7'(INIT_X);
            head_y       <= 7'(INIT_Y);
            len          <= LW'(INIT_LENGTH);
            dir          <= DIR_RIGHT;
            grow_pending <= 1'b0;
            idx          <= '0;
            fruit_eaten  <= 1'b0;
            body_count   <= '0;
            snake_body_x <= init_body_x(0);
            snake_body_y <= init_body_y(0);
            for (int k = 0; k < SNAKE_LENGTH_MAX; k++) begin
                body_x[k] <= init_body_x(k);
                body_y[k] <= init_body_y(k);
            end
        end else begin
            fruit_eaten <= 1'b0;
            case (state)
                ST_STREAM: begin
                    body_count   <= stream_next;
                    snake_body_x <= body_x[stream_next];
                    snake_body_y <= body_y[stream_next];
                    if (move_tick) begin
                        dir          <= dir_req;
                        grow_pending <= 1'b0;
                        idx          <= shift_first;
                        if (grow_now) len <= len + LW'(1);
                    end
                end
                ST_SHIFT: begin
                    body_x[idx]  <= body_x[idx_prev];
                    body_y[idx]  <= body_y[idx_prev];
                    idx          <= idx_prev;
                    body_count   <= '0;
                    snake_body_x <= body_x[0];
                    snake_body_y <= body_y[0];
                end
                ST_HEAD: begin
                    idx          <= '0;
                    body_count   <= '0;
                    snake_body_x <= body_x[0];
                    snake_body_y <= body_y[0];
                    if (!step_off_grid) begin
                        body_x[0] <= head_x;
                        body_y[0] <= head_y;
                        head_x    <= step_x;
                        head_y    <= step_y;
                        if (step_x == fruit_x && step_y == fruit_y) begin
                            fruit_eaten  <= 1'b1;
                            grow_pending <= 1'b1;
                        end
                    end
                end
                ST_CHECK: begin
                    idx          <= idx + SNAKE_LENGTH_BIT'(1);
                    body_count   <= '0;
                    snake_body_x <= body_x[0];
                    snake_body_y <= body_y[0];
                end
                ST_OVER: begin
                    if (start) begin
                        head_x       <= 7'(INIT_X);
                        head_y       <= 7'(INIT_Y);
                        len          <= LW'(INIT_LENGTH);
                        dir          <= DIR_RIGHT;
                        grow_pending <= 1'b0;
                        idx          <= '0;
                        body_count   <= '0;
                        snake_body_x <= init_body_x(0);
                        snake_body_y <= init_body_y(0);
                        for (int k = 0; k < SNAKE_LENGTH_MAX; k++) begin
                            body_x[k] <= init_body_x(k);
                            body_y[k] <= init_body_y(k);
                        end
                    end else begin
                        body_count   <= stream_next;
                        snake_body_x <= body_x[stream_next];
                        snake_body_y <= body_y[stream_next];
                    end
                end
                default: ;
            endcase
        end
    end

    assign snake_head_x = head_x;
    assign snake_head_y = head_y;
    // A full array (SNAKE_LENGTH_MAX) wraps to 0 on the narrower length port.
    assign snake_length = SNAKE_LENGTH_BIT'(len);

endmodule

// File: tb/tb_snake_motion_sequencer.sv
// Self-checking bench for snake_motion_sequencer: directed steps plus random play, checked
// against a queue-based snake model. Exercises the default (non-wrapping) edge behaviour.
module tb_snake_motion_sequencer;

    localparam int UP    = 0;
    localparam int DOWN  = 1;
    localparam int LEFT  = 2;
    localparam int RIGHT = 3;

    logic       clock_25 = 1'b0;
    logic       reset;
    logic       start;
    logic       move_tick;
    logic       up;
    logic       down;
    logic       left;
    logic       right;
    logic [6:0] fruit_x;
    logic [6:0] fruit_y;
    logic [6:0] snake_head_x;
    logic [6:0] snake_head_y;
    logic [6:0] snake_body_x;
    logic [6:0] snake_body_y;
    logic [3:0] body_count;
    logic [3:0] snake_length;
    logic       fruit_eaten;
    logic       game_over;
    logic       busy;

    int total = 0;
    int bad   = 0;

    // Reference snake: head, body list (index 0 right behind the head), direction, flags.
    int m_hx;
    int m_hy;
    int m_dir;
    bit m_grow;
    bit m_over;
    int m_bx[$];
    int m_by[$];
    int exp_busy;
    int exp_eat;

    snake_motion_sequencer dut (
        .clock_25     (clock_25),
        .reset        (reset),
        .start        (start),
        .move_tick    (move_tick),
        .up           (up),
        .down         (down),
        .left         (left),
        .right        (right),
        .fruit_x      (fruit_x),
        .fruit_y      (fruit_y),
        .snake_head_x (snake_head_x),
        .snake_head_y (snake_head_y),
        .snake_body_x (snake_body_x),
        .snake_body_y (snake_body_y),
        .body_count   (body_count),
        .snake_length (snake_length),
        .fruit_eaten  (fruit_eaten),
        .game_over    (game_over),
        .busy         (busy)
    );

    always #20 clock_25 = ~clock_25;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_hx   = 60;
        m_hy   = 40;
        m_dir  = RIGHT;
        m_grow = 1'b0;
        m_over = 1'b0;
        m_bx.delete();
        m_by.delete();
        for (int k = 0; k < 3; k++) begin
            m_bx.push_back(59 - k);
            m_by.push_back(40);
        end
    endfunction

    function automatic void model_step(input bit u, input bit d, input bit l, input bit r,
                                       input int fx, input int fy);
        int  req;
        int  nx;
        int  ny;
        int  newlen;
        int  hit;
        bit  out;
        exp_busy = 0;
        exp_eat  = 0;
        if (m_over) return;
        req = -1;
        if (u)      req = UP;
        else if (d) req = DOWN;
        else if (r) req = RIGHT;
        else if (l) req = LEFT;
        if (req >= 0 && req != (m_dir ^ 1)) m_dir = req;
        newlen = m_bx.size();
        if (m_grow && newlen < 16) newlen++;
        m_grow = 1'b0;
        nx  = m_hx + int'(m_dir == RIGHT) - int'(m_dir == LEFT);
        ny  = m_hy + int'(m_dir == DOWN) - int'(m_dir == UP);
        out = (nx < 0) || (nx >= 124) || (ny < 0) || (ny >= 81);
        if (out) begin
            // Body still shifts, but the head never moves into body[0].
            m_bx.push_front(m_bx[0]);
            m_by.push_front(m_by[0]);
        end else begin
            m_bx.push_front(m_hx);
            m_by.push_front(m_hy);
            m_hx = nx;
            m_hy = ny;
        end
        while (m_bx.size() > newlen) begin
            void'(m_bx.pop_back());
            void'(m_by.pop_back());
        end
        if (out) begin
            m_over   = 1'b1;
            exp_busy = newlen;
            return;
        end
        if (m_hx == fx && m_hy == fy) begin
            exp_eat = 1;
            m_grow  = 1'b1;
        end
        hit = -1;
        for (int k = 0; k < newlen; k++)
            if (hit < 0 && m_bx[k] == m_hx && m_by[k] == m_hy) hit = k;
        exp_busy = newlen + ((hit >= 0) ? hit + 1 : newlen);
        if (hit >= 0) m_over = 1'b1;
    endfunction

    task automatic check_state(input string tag);
        check({tag, ".head_x"}, 32'(snake_head_x), 32'(m_hx));
        check({tag, ".head_y"}, 32'(snake_head_y), 32'(m_hy));
        check({tag, ".length"}, 32'(snake_length), 32'(m_bx.size() % 16));
        check({tag, ".game_over"}, 32'(game_over), 32'(m_over));
        check({tag, ".busy"}, 32'(busy), 32'd0);
    endtask

    task automatic check_stream(input string tag);
        int waited;
        waited = 0;
        while (body_count !== 4'd0 && waited < 40) begin
            waited++;
            @(negedge clock_25);
        end
        check({tag, ".stream_sync"}, 32'(body_count), 32'd0);
        for (int i = 0; i < m_bx.size(); i++) begin
            check({tag, ".body_count"}, 32'(body_count), 32'(i % 16));
            check({tag, ".body_x"}, 32'(snake_body_x), 32'(m_bx[i]));
            check({tag, ".body_y"}, 32'(snake_body_y), 32'(m_by[i]));
            @(negedge clock_25);
        end
        check({tag, ".stream_wrap"}, 32'(body_count), 32'd0);
    endtask

    // Issue one move_tick at a negedge; optionally pulse another one while busy.
    task automatic do_step(input string tag, input bit u, input bit d, input bit l, input bit r,
                           input int fx, input int fy, input bit extra);
        int cycles;
        int eats;
        model_step(u, d, l, r, fx & 127, fy & 127);
        up        = u;
        down      = d;
        left      = l;
        right     = r;
        fruit_x   = 7'(fx);
        fruit_y   = 7'(fy);
        move_tick = 1'b1;
        @(negedge clock_25);
        move_tick = 1'b0;
        up        = 1'b0;
        down      = 1'b0;
        left      = 1'b0;
        right     = 1'b0;
        cycles    = 0;
        eats      = 0;
        while (busy === 1'b1 && cycles < 200) begin
            cycles++;
            if (fruit_eaten === 1'b1) eats++;
            move_tick = extra && (cycles == 2);
            @(negedge clock_25);
        end
        move_tick = 1'b0;
        if (fruit_eaten === 1'b1) eats++;
        check({tag, ".busy_cycles"}, 32'(cycles), 32'(exp_busy));
        check({tag, ".fruit_eaten"}, 32'(eats), 32'(exp_eat));
        check_state(tag);
        check_stream(tag);
    endtask

    task automatic pulse_start(input string tag);
        start = 1'b1;
        @(negedge clock_25);
        start = 1'b0;
        if (m_over) model_reset();
        check_state(tag);
        check_stream(tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        check({tag, ".head_x"}, 32'(snake_head_x), 32'd60);
        check({tag, ".head_y"}, 32'(snake_head_y), 32'd40);
        check({tag, ".length"}, 32'(snake_length), 32'd3);
        check({tag, ".busy"}, 32'(busy), 32'd0);
        check({tag, ".game_over"}, 32'(game_over), 32'd0);
        check({tag, ".fruit_eaten"}, 32'(fruit_eaten), 32'd0);
        check({tag, ".body_count"}, 32'(body_count), 32'd0);
        check({tag, ".body_x"}, 32'(snake_body_x), 32'd59);
        check({tag, ".body_y"}, 32'(snake_body_y), 32'd40);
        @(negedge clock_25);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int fx;
        int fy;
        reset     = 1'b0;
        start     = 1'b0;
        move_tick = 1'b0;
        up        = 1'b0;
        down      = 1'b0;
        left      = 1'b0;
        right     = 1'b0;
        fruit_x   = 7'd0;
        fruit_y   = 7'd0;
        #5;
        do_reset("reset");
        check_state("reset");
        check_stream("reset");

        do_step("plain_right", 0, 0, 0, 0, 0, 0, 0);
        do_step("eat", 0, 0, 0, 0, 62, 40, 0);
        do_step("grow", 0, 0, 0, 0, 0, 0, 1);
        do_step("opposite", 0, 0, 1, 0, 0, 0, 0);
        do_step("priority", 1, 0, 1, 0, 0, 0, 0);
        pulse_start("start_ignored");

        do_reset("reset2");
        do_step("c_eat1", 0, 0, 0, 0, 61, 40, 0);
        do_step("c_eat2", 0, 0, 0, 0, 62, 40, 0);
        do_step("c_grow", 0, 0, 0, 0, 0, 0, 0);
        do_step("c_up", 1, 0, 0, 0, 0, 0, 0);
        do_step("c_left", 0, 0, 1, 0, 0, 0, 0);
        do_step("c_down", 0, 1, 0, 0, 0, 0, 0);
        do_step("over_tick", 0, 0, 0, 0, 0, 0, 0);
        pulse_start("restart");

        // Reset while the step is in SHIFT.
        right     = 1'b1;
        move_tick = 1'b1;
        @(negedge clock_25);
        move_tick = 1'b0;
        right     = 1'b0;
        check("mid_shift.busy", 32'(busy), 32'd1);
        do_reset("mid_shift_reset");
        check_state("after_mid_reset");

        for (int n = 0; n < 63; n++) do_step("to_wall", 0, 0, 0, 0, 0, 0, 0);
        do_step("wall", 0, 0, 0, 0, 0, 0, 0);
        pulse_start("wall_restart");

        for (int n = 0; n < 120; n++) begin
            if (m_over) pulse_start("rnd_start");
            if ($urandom_range(0, 1) == 1) begin
                fx = m_hx + int'(m_dir == RIGHT) - int'(m_dir == LEFT);
                fy = m_hy + int'(m_dir == DOWN) - int'(m_dir == UP);
                do_step("rnd_feed", 0, 0, 0, 0, fx & 127, fy & 127, 0);
            end else begin
                fx = (m_hx + int'($urandom_range(0, 2)) - 1) & 127;
                fy = (m_hy + int'($urandom_range(0, 2)) - 1) & 127;
                do_step("rnd_turn", $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                        $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, fx, fy,
                        $urandom_range(0, 3) == 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
